// File: rtl/decodificador_3to8.sv
// decodificador_3to8: binary-to-one-hot decoder with enable, plus registered copy and change strobe
//    a    : binary select (N bits)
//    en   : active-high enable; low forces d to zero
//    d    : combinational one-hot decode (W = 2**N bits)
//    clk  : rising-edge clock for the registered path
//    rst  : asynchronous active-high reset, clears d_q and chg only
//    d_q  : d sampled at the most recent rising clk edge
//    chg  : high for one cycle whenever d_q takes a new value
module decodificador_3to8 #(
   parameter  int N = 3,
   localparam int W = 2**N
) (
   input  logic [N-1:0] a,
   input  logic         en,
   output logic [W-1:0] d,
   input  logic         clk,
   input  logic         rst,
   output logic [W-1:0] d_q,
   output logic         chg
);
   logic [W-1:0] w_d;
   logic [W-1:0] r_d_q;
   logic         r_chg;
   // An unknown select makes every comparison non-true, so all bits stay low
   always_comb begin
      w_d = '0;
      for (int i = 0; i < W; i++)
         if (en && (a == N'(i))) w_d[i] = 1'b1;
   end
   // chg compares the incoming decode against the value currently held
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_d_q <= '0;
         r_chg <= 1'b0;
      end else begin
         r_d_q <= w_d;
         r_chg <= (w_d != r_d_q);
      end
   end
   assign d   = w_d;
   assign d_q = r_d_q;
   assign chg = r_chg;
endmodule

// File: tb/tb_decodificador_3to8.sv
// tb_decodificador_3to8: directed self-checking bench for decodificador_3to8
module tb_decodificador_3to8;
   logic [2:0] a;
   logic       en;
   logic [7:0] d;
   logic       clk;
   logic       rst;
   logic [7:0] d_q;
   logic       chg;
   int n_cmp = 0;
   int n_err = 0;

   decodificador_3to8 dut (
      .a(a), .en(en), .d(d), .clk(clk), .rst(rst), .d_q(d_q), .chg(chg)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic test_reset();
      rst = 1'b1; en = 1'b1; a = 3'd4;
      repeat (2) @(posedge clk);
      #1;
      n_cmp++;
      if (d_q !== 8'h00) begin n_err++; $display("FAIL reset_d_q: got %h want 00", d_q); end
      n_cmp++;
      if (chg !== 1'b0) begin n_err++; $display("FAIL reset_chg: got %b want 0", chg); end
      n_cmp++;
      if (d !== 8'h10) begin n_err++; $display("FAIL reset_d_live: got %h want 10", d); end
   endtask

   task automatic test_sweep();
      logic [7:0] exp [8] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80};
      en = 1'b1;
      for (int i = 0; i < 8; i++) begin
         a = 3'(i);
         #20;
         n_cmp++;
         if (d !== exp[i]) begin n_err++; $display("FAIL sweep_a%0d: got %h want %h", i, d, exp[i]); end
         n_cmp++;
         if ($countones(d) != 1) begin n_err++; $display("FAIL onehot_a%0d: got %0d bits want 1", i, $countones(d)); end
      end
   endtask

   task automatic test_disable();
      en = 1'b0; a = 3'd7; #20;
      n_cmp++;
      if (d !== 8'h00) begin n_err++; $display("FAIL dis_a7: got %h want 00", d); end
      a = 3'd0; #20;
      n_cmp++;
      if (d !== 8'h00) begin n_err++; $display("FAIL dis_a0: got %h want 00", d); end
      en = 1'b1; a = 3'd3; #20;
      n_cmp++;
      if (d !== 8'h08) begin n_err++; $display("FAIL reenable_a3: got %h want 08", d); end
   endtask

   task automatic test_clocked();
      @(negedge clk);
      en = 1'b1; a = 3'd5; rst = 1'b0;
      @(posedge clk); #1;
      n_cmp++;
      if (d_q !== 8'h20) begin n_err++; $display("FAIL first_d_q: got %h want 20", d_q); end
      n_cmp++;
      if (chg !== 1'b1) begin n_err++; $display("FAIL first_chg: got %b want 1", chg); end
      @(posedge clk); #1;
      n_cmp++;
      if (chg !== 1'b0) begin n_err++; $display("FAIL hold_chg: got %b want 0", chg); end
      n_cmp++;
      if (d_q !== 8'h20) begin n_err++; $display("FAIL hold_d_q: got %h want 20", d_q); end
   endtask

   task automatic test_step_and_disable();
      @(negedge clk); a = 3'd6;
      @(posedge clk); #1;
      n_cmp++;
      if (d_q !== 8'h40 || chg !== 1'b1) begin n_err++; $display("FAIL step_5_6: got %h/%b want 40/1", d_q, chg); end
      @(posedge clk); #1;
      n_cmp++;
      if (chg !== 1'b0) begin n_err++; $display("FAIL step_pulse_end: got %b want 0", chg); end
      @(negedge clk); en = 1'b0;
      @(posedge clk); #1;
      n_cmp++;
      if (d_q !== 8'h00 || chg !== 1'b1) begin n_err++; $display("FAIL drop_en: got %h/%b want 00/1", d_q, chg); end
      @(negedge clk); en = 1'b1;
      @(posedge clk); #1;
      n_cmp++;
      if (d_q !== 8'h40 || chg !== 1'b1) begin n_err++; $display("FAIL reen_clk: got %h/%b want 40/1", d_q, chg); end
      @(posedge clk); #1;
      n_cmp++;
      if (d_q !== 8'h40 || chg !== 1'b0) begin n_err++; $display("FAIL reen_settle: got %h/%b want 40/0", d_q, chg); end
   endtask

   task automatic test_async_reset();
      @(negedge clk); #2;
      rst = 1'b1;
      #1;
      n_cmp++;
      if (d_q !== 8'h00) begin n_err++; $display("FAIL async_d_q: got %h want 00", d_q); end
      n_cmp++;
      if (chg !== 1'b0) begin n_err++; $display("FAIL async_chg: got %b want 0", chg); end
      n_cmp++;
      if (d !== 8'h40) begin n_err++; $display("FAIL async_d_live: got %h want 40", d); end
   endtask

   task automatic test_back_to_back();
      @(negedge clk);
      rst = 1'b0; en = 1'b1; a = 3'd0;
      @(posedge clk); #1;
      n_cmp++;
      if (d_q !== 8'h01 || chg !== 1'b1) begin n_err++; $display("FAIL release_edge: got %h/%b want 01/1", d_q, chg); end
      for (int k = 1; k < 8; k++) begin
         @(negedge clk); a = 3'(k);
         @(posedge clk); #1;
         n_cmp++;
         if (d_q !== (8'h01 << k) || chg !== 1'b1) begin
            n_err++; $display("FAIL b2b_%0d: got %h/%b want %h/1", k, d_q, chg, 8'h01 << k);
         end
      end
   endtask

   task automatic test_glitch();
      @(negedge clk);
      a = 3'd2; #1 a = 3'd0; #1 en = 1'b0; #1 en = 1'b1; a = 3'd4;
      @(posedge clk); #1;
      n_cmp++;
      if (d_q !== 8'h10 || chg !== 1'b1) begin n_err++; $display("FAIL glitch_capture: got %h/%b want 10/1", d_q, chg); end
   endtask

   task automatic test_x_select();
      logic [7:0] exp;
      @(negedge clk);
      en = 1'b1; a = 3'bxxx;
      #1;
      exp = $isunknown(a) ? 8'h00 : (8'h01 << a);
      n_cmp++;
      if (d !== exp) begin n_err++; $display("FAIL x_select_d: got %h want %h", d, exp); end
      n_cmp++;
      if ($isunknown(d)) begin n_err++; $display("FAIL x_select_noprop: got %b want no X", d); end
      a = 3'd1;
   endtask

   initial begin
      a = 3'd0; en = 1'b0; rst = 1'b1;
      test_reset();
      test_sweep();
      test_disable();
      test_clocked();
      test_step_and_disable();
      test_async_reset();
      test_back_to_back();
      test_glitch();
      test_x_select();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
